// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the program-run sequencer.
// Includes the state encoding, the per-program entry addresses and the default watchdog limit.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          PROG_PC_W      = 10;
  localparam int unsigned DEF_MAX_CYCLES = 60000;

  localparam logic [PROG_PC_W-1:0] PROG_BASE [0:3] = '{
    10'd0, 10'd128, 10'd256, 10'd384
  };

endpackage

// File: rtl/run_ctrl.sv
// Program-run sequencer: parks the core, selects an entry address, releases the core,
// then counts RUN cycles until a halt or a watchdog timeout.
//
// Host handshake (level based): the host raises Start to request a run and holds it
// while the core is armed. Dropping Start releases the core. Ack stays high in DONE
// until the next Start, and Start in RUN aborts the current run and re-arms the core.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          PC_W       = 10,
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             CoreHalt,
  output logic             CoreStart,
  output logic [PC_W-1:0]  StartPC,
  output logic             Busy,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCt,
  output state_t           DbgState
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;
  logic             at_limit;

  assign at_limit = (cnt_q == LIMIT_M1);

  // State register with the inline cycle counter, entry-address latch and timeout flag.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            pc_q  <= PC_W'(PROG_BASE[ProgSel]);
            cnt_q <= '0;
            to_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (Start) begin
            pc_q  <= PC_W'(PROG_BASE[ProgSel]);
            cnt_q <= '0;
            to_q  <= 1'b0;
          end else if (!CoreHalt) begin
            // The counter stops at MAX_CYCLES because reaching the limit leaves RUN.
            cnt_q <= cnt_q + CNT_W'(1);
            if (at_limit) to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_ARM;
      ST_ARM:  if (!Start) state_d = ST_RUN;
      ST_RUN: begin
        if (Start)                     state_d = ST_ARM;
        else if (CoreHalt || at_limit) state_d = ST_DONE;
      end
      ST_DONE: if (Start) state_d = ST_ARM;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CoreStart = 1'b1;
    Busy      = 1'b0;
    Ack       = 1'b0;
    case (state_q)
      ST_ARM:  Busy = 1'b1;
      ST_RUN: begin
        CoreStart = 1'b0;
        Busy      = 1'b1;
      end
      ST_DONE: Ack = 1'b1;
      default: ;
    endcase
  end

  assign StartPC  = pc_q;
  assign CycleCt  = cnt_q;
  assign Timeout  = to_q;
  assign DbgState = state_q;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Program-run sequencer that sits between the testbench/host handshake (Start, ProgSel, Ack) and the processor core. It parks the core's fetch unit, selects a program entry address, releases the core, and counts executed cycles. It detects the core's halt instruction or a watchdog timeout and then presents a registered done/Ack with the final cycle count. It replaces the ad-hoc cycle counter and Ack wiring in the top level.

## Interface
Parameters:
- PC_W, 10, program-counter width; matches InstFetch target width
- CNT_W, 16, cycle-counter width
- MAX_CYCLES, 16'd60000, watchdog limit in RUN cycles; must be ≥1 and < 2^CNT_W

Ports:
- Clk  in  1  clock, posedge only
- ResetN  in  1  asynchronous, active-low reset
- Start  in  1  host run request, level
- ProgSel  in  2  program index, captured on ARM entry
- CoreHalt  in  1  core halt indication (all-ones instruction decoded)
- CoreStart  out  1  to InstFetch Start; 1 holds PC at StartPC
- StartPC  out  PC_W  entry address presented to InstFetch while CoreStart=1
- Busy  out  1  1 in ARM or RUN
- Ack  out  1  run complete; 1 only in DONE
- Timeout  out  1  last run ended by watchdog; valid while Ack=1
- CycleCt  out  CNT_W  RUN-cycle count of current/last run

## Operation
- States: IDLE, ARM, RUN, DONE (state_t, 2 bits).
- Reset (async, ResetN=0): state=IDLE, CoreStart=1, StartPC=0, Busy=0, Ack=0, Timeout=0, CycleCt=0. Asserting ResetN=0 mid-run aborts immediately; no partial results retained.
- IDLE: CoreStart=1. Start=1 → ARM; latch ProgSel, load StartPC=PROG_BASE[ProgSel], clear CycleCt and Timeout.
- ARM: CoreStart=1, Busy=1. Stay while Start=1. Start=0 → RUN. ProgSel changes during ARM are ignored.
- RUN: CoreStart=0, Busy=1. Each cycle:
  - CoreHalt=1 → DONE; CycleCt not incremented on that cycle.
  - else if CycleCt==MAX_CYCLES-1 → increment to MAX_CYCLES, go to DONE, set Timeout=1.
  - else CycleCt+1.
  - Start=1 → abort: go to ARM with a new ProgSel latch, clear CycleCt and Timeout. This takes priority over halt and timeout.
  - Halt and timeout on the same cycle: halt wins, Timeout=0, CycleCt=MAX_CYCLES-1.
- DONE: Ack=1, CoreStart=1 (core re-parked), CycleCt/Timeout held. Start=1 → ARM, with the same actions as from IDLE.
- CycleCt never wraps; its maximum value is MAX_CYCLES.

## Timing
- All outputs are registered; state-derived outputs change on the Clk edge after the decision.
- Start rise in IDLE/DONE at edge N: ARM from N, StartPC valid from N.
- Start fall sampled at edge M: RUN from M. The first CycleCt increment happens at edge M+1 if CoreHalt=0.
- CoreHalt sampled at edge K in RUN: Ack=1 from K, Busy=0 from K.
- Minimum run (halt on the first RUN cycle): CycleCt=0, Ack one cycle after RUN entry.
- Ack stays high until the next Start; there is no auto-clear.

## Structure
- Shared package run_ctrl_pkg:
  - state_t enum
  - PROG_BASE: 4-entry array of PC_W-bit entry addresses; defaults 0, 10'd128, 10'd256, 10'd384
  - DEF_MAX_CYCLES constant
- Single module; no sub-module needed. The counter is inline, with its saturation/limit compare in the same always_ff as the state register.
- Top level connects: CoreHalt = &Instruction; CoreStart → InstFetch Start; StartPC → InstFetch start-target mux.

## Test plan
- Reset then idle: ResetN low mid-RUN with CycleCt=37 → all outputs at reset values the same cycle. After release, state stays IDLE with CoreStart=1 and Ack=0.
- Normal run: ProgSel=2, Start high 3 cycles then low, CoreHalt raised after 20 RUN cycles → StartPC=256 during ARM, Ack=1, CycleCt=20, Timeout=0.
- Watchdog: MAX_CYCLES=50, CoreHalt never asserted → Ack=1 exactly 50 cycles after RUN entry, CycleCt=50, Timeout=1.
- Simultaneous: MAX_CYCLES=50, CoreHalt on the 50th RUN cycle → Timeout=0, CycleCt=49.
- Abort/restart: Start reasserted in RUN at CycleCt=12 with ProgSel=1 → ARM next cycle, CycleCt=0, StartPC=128. The following run completes normally.
- Back-to-back: second Start from DONE with ProgSel=3 → Ack drops on the ARM edge, StartPC=384, second CycleCt independent of the first.
